multi_chan_pulse_sync: RTL and testbench
========================================

// Module: multi_chan_pulse_sync
// PURPOSE
//  N-channel asynchronous-input synchronizer with edge/toggle pulse recovery and per-channel event counting.
//  Sits at the receive side of a clock-domain crossing: each async_in bit comes from another domain
//  (level or toggle-encoded pulse) and is resynchronized into clk. A one-cycle pulse_out is produced per detected event.
//  Generalises the single-bit two-clock pulse synchronizer: adds channel count, stage depth, mode and counters.
// PARAMETERS
//  CH        4  number of independent channels (>=1)
//  STAGES    2  synchronizer flops per channel (>=2)
//  CW        8  event counter width per channel (>=1)
//  FILT_CYC  3  stable cycles required by glitch filter (>=1; used only with MCPS_DEBOUNCE_EN)
// PORTS
//  clk        in   1      destination clock; all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  async_in   in   CH     asynchronous inputs, one per channel, no timing relation to clk
//  mode       in   2*CH   per-channel mode, ch i at [2i+1:2i]; quasi-static
//  cnt_clr    in   CH     synchronous per-channel counter/overflow clear
//  sync_out   out  CH     synchronized (and filtered) level
//  pulse_out  out  CH     one-cycle event pulse
//  evt_cnt    out  CH*CW  per-channel saturating event count, ch i at [CW*i+CW-1:CW*i]
//  ovf        out  CH     sticky: increment attempted while count at max
// BEHAVIOUR
//  Reset (rst_n=0, async): sync chain, filter, edge reg, pulse_out, evt_cnt, ovf all 0.
//  Sync chain: s[0]<=async_in; s[k]<=s[k-1]; level L = s[STAGES-1]. No logic between chain flops.
//  Latency: value captured at edge k appears on sync_out after edge k+STAGES-1.
//  Edge reg d<=sync_out every cycle regardless of mode. pulse_out registered: high for exactly the cycle after
//   edge k+STAGES, i.e. STAGES+1 edges after capture. Back-to-back events spaced >=1 cycle each give a pulse.
//  Modes: 00 LEVEL  pulse_out=0, sync_out only
//         01 RISE   pulse on sync_out 0->1
//         10 FALL   pulse on sync_out 1->0
//         11 TOGGLE pulse on any change (toggle-encoded pulse transfer)
//  Mode change: effective next cycle; because d always tracks, a mode change never creates a spurious pulse.
//  Counter: +1 on each pulse_out cycle (counts the registered pulse, 1 cycle after it). At 2^CW-1 holds and sets ovf.
//   cnt_clr[i] alone: cnt=0, ovf=0. cnt_clr with increment same cycle: cnt=1, ovf=0 (clear wins, then count).
//  Input high at reset release: treated as 0->1 edge; RISE/TOGGLE channel pulses once after STAGES+1 cycles.
//  Reset mid-operation: immediate clear of all state; in-flight events are lost, no pulse after release
//   unless input level differs from 0.
//  Channels fully independent; no cross-channel coherence guaranteed (multi-bit buses must not use this block).
// CONFIGURATION
//  MCPS_DEBOUNCE_EN defined: glitch filter between L and sync_out per channel. Filter counter (clog2(FILT_CYC+1) bits)
//   increments while L!=sync_out, resets to 0 when L==sync_out; when it reaches FILT_CYC, sync_out<=L and counter 0.
//   Adds FILT_CYC cycles latency; input pulses shorter than FILT_CYC clk cycles at L are suppressed.
//  Not defined: sync_out = L directly, FILT_CYC ignored, no filter flops.
// STRUCTURE
//  Package mcps_pkg: typedef enum logic[1:0] {MODE_LEVEL, MODE_RISE, MODE_FALL, MODE_TOGGLE}; parameter checks.
//  Sub-module mcps_chan (one channel: chain, optional filter, edge detect, counter), generate-looped CH times;
//   top only slices buses.
// TESTING
//  1 CH=4,STAGES=2, ch0 RISE, async_in[0] 0->1 held -> sync_out[0]=1 after 2 edges, single pulse_out[0] cycle
//    3 edges after capture, evt_cnt[0]=1.
//  2 ch1 TOGGLE, 5 toggles each held 4 cycles -> 5 pulses, evt_cnt[1]=5; ch1 LEVEL same stimulus -> 0 pulses, cnt 0.
//  3 CW=3, ch2 RISE, 9 rising edges -> evt_cnt[2]=7, ovf[2]=1; cnt_clr[2] coincident with 10th pulse -> cnt=1, ovf=0.
//  4 async_in=4'hF during reset, release -> RISE/TOGGLE channels pulse once at cycle STAGES+1, FALL/LEVEL none.
//  5 rst_n low mid-chain (input edge 1 cycle after capture) -> all outputs 0 immediately, no pulse after release.
//  6 MCPS_DEBOUNCE_EN, FILT_CYC=3: 2-cycle glitch -> no sync_out change, no pulse; 4-cycle high -> pulse,
//    latency STAGES+FILT_CYC+1.

Source files
------------

// File: rtl/mcps_pkg.sv
// Shared types and helpers for multi_chan_pulse_sync: channel mode encoding,
// per-mode event detection and elaboration-time parameter legality.
package mcps_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL  = 2'b00,
      MODE_RISE   = 2'b01,
      MODE_FALL   = 2'b10,
      MODE_TOGGLE = 2'b11
   } mode_e;

   function automatic logic evt_detect(input mode_e m, input logic cur, input logic prev);
      logic evt;
      evt = 1'b0;
      case (m)
         MODE_RISE:   evt = cur & ~prev;
         MODE_FALL:   evt = ~cur & prev;
         MODE_TOGGLE: evt = cur ^ prev;
         default:     evt = 1'b0;
      endcase
      return evt;
   endfunction

   function automatic bit params_ok(input int ch, input int stages, input int cw, input int filt_cyc);
      return (ch >= 1) && (stages >= 2) && (cw >= 1) && (filt_cyc >= 1);
   endfunction

endpackage

// File: rtl/mcps_chan.sv
// One channel: STAGES-flop synchronizer, optional glitch filter (MCPS_DEBOUNCE_EN), edge/toggle
// pulse recovery and saturating event counter. Pulse lags capture by STAGES edges; no backpressure.
module mcps_chan
   import mcps_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int CW     = 8
`ifdef MCPS_DEBOUNCE_EN
   ,
   parameter int FILT_CYC = 3
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          async_in,
   input  logic [1:0]    mode,
   input  logic          cnt_clr,
   output logic          sync_out,
   output logic          pulse_out,
   output logic [CW-1:0] evt_cnt,
   output logic          ovf
);

   logic [STAGES-1:0] sync_ff;
   logic              level;
   logic              sync_d;

   // Pure flop chain: nothing may sit between these stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], async_in};
      end
   end

   assign level = sync_ff[STAGES-1];

`ifdef MCPS_DEBOUNCE_EN
   localparam int FW = $clog2(FILT_CYC + 1);

   logic [FW-1:0] filt_cnt;
   logic          filt_q;

   // Level must disagree with the filtered output for FILT_CYC consecutive edges before it is adopted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt <= '0;
         filt_q   <= 1'b0;
      end else if (level == filt_q) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_CYC - 1)) begin
         filt_cnt <= '0;
         filt_q   <= level;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign sync_out = filt_q;
`else
   assign sync_out = level;
`endif

   // sync_d tracks regardless of mode, so switching mode cannot fabricate an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_d    <= 1'b0;
         pulse_out <= 1'b0;
      end else begin
         sync_d    <= sync_out;
         pulse_out <= evt_detect(mode_e'(mode), sync_out, sync_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt <= '0;
         ovf     <= 1'b0;
      end else if (cnt_clr) begin
         evt_cnt <= CW'(pulse_out);
         ovf     <= 1'b0;
      end else if (pulse_out) begin
         if (evt_cnt == {CW{1'b1}}) begin
            ovf <= 1'b1;
         end else begin
            evt_cnt <= evt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_chan_pulse_sync.sv
// CH independent async-input synchronizers with pulse recovery and event counters; glitch filter
// under MCPS_DEBOUNCE_EN. Pulse STAGES edges after capture (+FILT_CYC when filtered); no backpressure.
module multi_chan_pulse_sync
   import mcps_pkg::*;
#(
   parameter int CH       = 4,
   parameter int STAGES   = 2,
   parameter int CW       = 8,
   parameter int FILT_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CH-1:0]    async_in,
   input  logic [2*CH-1:0]  mode,
   input  logic [CH-1:0]    cnt_clr,
   output logic [CH-1:0]    sync_out,
   output logic [CH-1:0]    pulse_out,
   output logic [CH*CW-1:0] evt_cnt,
   output logic [CH-1:0]    ovf
);

   if (!params_ok(CH, STAGES, CW, FILT_CYC)) begin : g_bad_params
      $error("multi_chan_pulse_sync: illegal parameter set");
   end

   for (genvar i = 0; i < CH; i++) begin : g_chan
      mcps_chan #(
         .STAGES   (STAGES),
         .CW       (CW)
`ifdef MCPS_DEBOUNCE_EN
         ,
         .FILT_CYC (FILT_CYC)
`endif
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .async_in  (async_in[i]),
         .mode      (mode[2*i +: 2]),
         .cnt_clr   (cnt_clr[i]),
         .sync_out  (sync_out[i]),
         .pulse_out (pulse_out[i]),
         .evt_cnt   (evt_cnt[CW*i +: CW]),
         .ovf       (ovf[i])
      );
   end

endmodule

// File: tb/tb_multi_chan_pulse_sync.sv
// Self-checking bench for multi_chan_pulse_sync: directed scenarios plus randomized traffic,
// all compared against a delay-line/rule reference model of the channel behaviour.
module tb_multi_chan_pulse_sync;
   import mcps_pkg::*;

   localparam int CH       = 4;
   localparam int STAGES   = 2;
   localparam int CW       = 3;
   localparam int FILT_CYC = 3;
`ifdef MCPS_DEBOUNCE_EN
   localparam int FD = FILT_CYC;
`else
   localparam int FD = 0;
`endif
   localparam int VW = 3*CH + CH*CW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CH-1:0]    async_in = '0;
   logic [2*CH-1:0]  mode = '0;
   logic [CH-1:0]    cnt_clr = '0;
   logic [CH-1:0]    sync_out;
   logic [CH-1:0]    pulse_out;
   logic [CH*CW-1:0] evt_cnt;
   logic [CH-1:0]    ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_chan_pulse_sync #(
      .CH(CH), .STAGES(STAGES), .CW(CW), .FILT_CYC(FILT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .async_in(async_in), .mode(mode), .cnt_clr(cnt_clr),
      .sync_out(sync_out), .pulse_out(pulse_out), .evt_cnt(evt_cnt), .ovf(ovf)
   );

   // ---------------- reference model ----------------
   logic [CH-1:0] hist[$];            // input samples captured at each edge since reset
   logic [CH-1:0] m_sync, m_sync_prev, m_pulse, m_ovf;
   logic [CW-1:0] m_cnt[CH];
   int            m_run[CH];

   function automatic logic m_event(input logic [1:0] md, input logic cur, input logic prv);
      if (md == 2'b01) return cur && !prv;
      if (md == 2'b10) return !cur && prv;
      if (md == 2'b11) return cur != prv;
      return 1'b0;
   endfunction

   task automatic model_clear();
      hist.delete();
      m_sync = '0; m_sync_prev = '0; m_pulse = '0; m_ovf = '0;
      for (int c = 0; c < CH; c++) begin m_cnt[c] = '0; m_run[c] = 0; end
   endtask

   task automatic model_step();
      logic [CH-1:0] raw;
      for (int c = 0; c < CH; c++) begin
         if (cnt_clr[c]) begin
            m_cnt[c] = m_pulse[c] ? CW'(1) : CW'(0);
            m_ovf[c] = 1'b0;
         end else if (m_pulse[c]) begin
            if (m_cnt[c] == {CW{1'b1}}) m_ovf[c] = 1'b1;
            else m_cnt[c] = m_cnt[c] + 1'b1;
         end
      end
      for (int c = 0; c < CH; c++)
         m_pulse[c] = m_event(mode[2*c +: 2], m_sync[c], m_sync_prev[c]);
      m_sync_prev = m_sync;
      hist.push_back(async_in);
      if (hist.size() > STAGES + 1) void'(hist.pop_front());
      raw = (hist.size() >= STAGES) ? hist[hist.size() - STAGES] : '0;
`ifdef MCPS_DEBOUNCE_EN
      for (int c = 0; c < CH; c++) begin
         if (raw[c] != m_sync[c]) begin
            m_run[c]++;
            if (m_run[c] == FILT_CYC) begin m_sync[c] = raw[c]; m_run[c] = 0; end
         end else begin
            m_run[c] = 0;
         end
      end
`else
      m_sync = raw;
`endif
   endtask

   function automatic logic [VW-1:0] m_vec();
      logic [CH*CW-1:0] ev;
      for (int c = 0; c < CH; c++) ev[c*CW +: CW] = m_cnt[c];
      return {m_sync, m_pulse, ev, m_ovf};
   endfunction

   // Advance one clock; returns 1 time unit after the edge with the model updated.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_clear(); else model_step();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; model_clear();
      async_in = 4'hA;
      repeat (3) tick();
      checks++; if (sync_out !== '0)  begin errors++; $display("FAIL reset_sync got %h exp 0", sync_out); end
      checks++; if (pulse_out !== '0) begin errors++; $display("FAIL reset_pulse got %h exp 0", pulse_out); end
      checks++; if (evt_cnt !== '0)   begin errors++; $display("FAIL reset_cnt got %h exp 0", evt_cnt); end
      checks++; if (ovf !== '0)       begin errors++; $display("FAIL reset_ovf got %h exp 0", ovf); end
      async_in = '0;
      #3 rst_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_rise();
      int sync_e, pulse_e, npulse;
      sync_e = 0; pulse_e = 0; npulse = 0;
      mode = 8'b00_00_00_01; cnt_clr = '1;
      tick(); cnt_clr = '0;
      repeat (3) tick();
      async_in[0] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         checks++;
         if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
            errors++; $display("FAIL rise_model e=%0d got %h exp %h", e, {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
         end
         if (sync_out[0] && sync_e == 0) sync_e = e;
         if (pulse_out[0]) begin npulse++; pulse_e = e; end
      end
      checks++; if (sync_e !== STAGES + FD)      begin errors++; $display("FAIL rise_sync_lat got %0d exp %0d", sync_e, STAGES + FD); end
      checks++; if (npulse !== 1)                begin errors++; $display("FAIL rise_npulse got %0d exp 1", npulse); end
      checks++; if (pulse_e !== STAGES + 1 + FD) begin errors++; $display("FAIL rise_pulse_lat got %0d exp %0d", pulse_e, STAGES + 1 + FD); end
      checks++; if (evt_cnt[CW-1:0] !== CW'(1))  begin errors++; $display("FAIL rise_cnt got %0d exp 1", evt_cnt[CW-1:0]); end
      async_in[0] = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_toggle();
      int npulse;
      for (int pass = 0; pass < 2; pass++) begin
         npulse = 0;
         mode[3:2] = (pass == 0) ? 2'b11 : 2'b00;
         cnt_clr = 4'b0010; tick(); cnt_clr = '0;
         for (int t = 0; t < 5; t++) begin
            async_in[1] = ~async_in[1];
            for (int h = 0; h < 4; h++) begin
               tick();
               checks++;
               if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
                  errors++; $display("FAIL toggle_model pass=%0d got %h exp %h", pass, {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
               end
               if (pulse_out[1]) npulse++;
            end
         end
         for (int h = 0; h < 8; h++) begin tick(); if (pulse_out[1]) npulse++; end
         checks++; if (npulse !== (pass == 0 ? 5 : 0)) begin errors++; $display("FAIL toggle_npulse pass=%0d got %0d exp %0d", pass, npulse, (pass == 0 ? 5 : 0)); end
         checks++; if (evt_cnt[CW +: CW] !== CW'(pass == 0 ? 5 : 0)) begin
            errors++; $display("FAIL toggle_cnt pass=%0d got %0d exp %0d", pass, evt_cnt[CW +: CW], (pass == 0 ? 5 : 0));
         end
      end
      async_in[1] = 1'b0; mode[3:2] = 2'b00;
      repeat (8) tick();
   endtask

   task automatic test_saturate();
      bit seen;
      mode[5:4] = 2'b01;
      cnt_clr = 4'b0100; tick(); cnt_clr = '0;
      for (int n = 0; n < 9; n++) begin
         async_in[2] = 1'b1; repeat (4) tick();
         async_in[2] = 1'b0; repeat (4) tick();
         checks++;
         if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
            errors++; $display("FAIL sat_model n=%0d got %h exp %h", n, {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
         end
      end
      repeat (6) tick();
      checks++; if (evt_cnt[2*CW +: CW] !== CW'(7)) begin errors++; $display("FAIL sat_cnt got %0d exp 7", evt_cnt[2*CW +: CW]); end
      checks++; if (ovf[2] !== 1'b1)                begin errors++; $display("FAIL sat_ovf got %b exp 1", ovf[2]); end
      async_in[2] = 1'b1;
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
         tick();
         if (pulse_out[2]) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL sat_pulse_timeout got none exp pulse within 20 cycles"); end
      cnt_clr[2] = 1'b1; tick(); cnt_clr[2] = 1'b0;
      checks++; if (evt_cnt[2*CW +: CW] !== CW'(1)) begin errors++; $display("FAIL clr_inc_cnt got %0d exp 1", evt_cnt[2*CW +: CW]); end
      checks++; if (ovf[2] !== 1'b0)                begin errors++; $display("FAIL clr_inc_ovf got %b exp 0", ovf[2]); end
      async_in[2] = 1'b0; mode[5:4] = 2'b00;
      repeat (8) tick();
   endtask

   task automatic test_reset_high();
      int npulse[CH];
      int pedge[CH];
      #2 rst_n = 1'b0; model_clear();
      mode = 8'b00_10_11_01;
      async_in = 4'hF;
      repeat (2) tick();
      #3 rst_n = 1'b1;
      for (int c = 0; c < CH; c++) begin npulse[c] = 0; pedge[c] = 0; end
      for (int e = 1; e <= 10; e++) begin
         tick();
         checks++;
         if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
            errors++; $display("FAIL rsthigh_model e=%0d got %h exp %h", e, {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
         end
         for (int c = 0; c < CH; c++) if (pulse_out[c]) begin npulse[c]++; pedge[c] = e; end
      end
      for (int c = 0; c < CH; c++) begin
         checks++;
         if (npulse[c] !== (c < 2 ? 1 : 0)) begin errors++; $display("FAIL rsthigh_npulse ch=%0d got %0d exp %0d", c, npulse[c], (c < 2 ? 1 : 0)); end
      end
      checks++; if (pedge[0] !== STAGES + 1 + FD) begin errors++; $display("FAIL rsthigh_edge got %0d exp %0d", pedge[0], STAGES + 1 + FD); end
      async_in = '0; mode = '0;
      repeat (8) tick();
   endtask

   task automatic test_reset_mid();
      int npulse;
      npulse = 0;
      mode = 8'hFF; cnt_clr = '1; tick(); cnt_clr = '0;
      repeat (4) tick();
      async_in = 4'hF;
      tick();
      #2 rst_n = 1'b0; model_clear();
      #1;
      checks++; if ({sync_out, pulse_out, evt_cnt, ovf} !== '0) begin
         errors++; $display("FAIL rstmid_clear got %h exp 0", {sync_out, pulse_out, evt_cnt, ovf});
      end
      async_in = '0;
      repeat (2) tick();
      #3 rst_n = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (pulse_out != '0) npulse++;
      end
      checks++; if (npulse !== 0) begin errors++; $display("FAIL rstmid_npulse got %0d exp 0", npulse); end
      checks++; if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
         errors++; $display("FAIL rstmid_model got %h exp %h", {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
      end
      mode = '0;
   endtask

   task automatic test_debounce();
`ifdef MCPS_DEBOUNCE_EN
      int npulse, sync_hi, pedge;
      npulse = 0; sync_hi = 0; pedge = 0;
      mode[7:6] = 2'b01; cnt_clr = '1; tick(); cnt_clr = '0;
      repeat (4) tick();
      async_in[3] = 1'b1; repeat (2) tick(); async_in[3] = 1'b0;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (sync_out[3]) sync_hi++;
         if (pulse_out[3]) npulse++;
      end
      checks++; if (sync_hi !== 0) begin errors++; $display("FAIL deb_glitch_sync got %0d exp 0", sync_hi); end
      checks++; if (npulse !== 0)  begin errors++; $display("FAIL deb_glitch_pulse got %0d exp 0", npulse); end
      async_in[3] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 4) async_in[3] = 1'b0;
         if (pulse_out[3]) begin npulse++; pedge = e; end
      end
      checks++; if (npulse !== 1) begin errors++; $display("FAIL deb_pulse_count got %0d exp 1", npulse); end
      checks++; if (pedge !== STAGES + FILT_CYC + 1) begin errors++; $display("FAIL deb_latency got %0d exp %0d", pedge, STAGES + FILT_CYC + 1); end
      mode = '0; async_in = '0;
      repeat (10) tick();
`endif
   endtask

   task automatic test_random();
      int hold[CH];
      for (int c = 0; c < CH; c++) hold[c] = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 200 == 0) mode = 2*CH'($urandom);
         for (int c = 0; c < CH; c++) begin
            hold[c]--;
            if (hold[c] == 0) begin
               async_in[c] = ~async_in[c];
               hold[c] = $urandom_range(1, 7);
            end
         end
         cnt_clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
         tick();
         checks++;
         if ({sync_out, pulse_out, evt_cnt, ovf} !== m_vec()) begin
            errors++; $display("FAIL random_model cyc=%0d got %h exp %h", cyc, {sync_out, pulse_out, evt_cnt, ovf}, m_vec());
         end
      end
      cnt_clr = '0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_rise();
      test_toggle();
      test_saturate();
      test_reset_high();
      test_reset_mid();
      test_debounce();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
